// File: rtl/bcd_scan_display.sv
// Binary-to-BCD converter (sequential double-dabble) driving a 4-of-8 digit, active-low
// multiplexed 7-segment bus. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_scan_display #(
    parameter int VALUE_W  = 10,
    parameter int SCAN_DIV = 41666
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [VALUE_W-1:0] VALUE,
    input  logic               ERR,
    input  logic               LOAD,
    output logic               BUSY,
    output logic [15:0]        DISPLAY
);

    localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ITER_W = $clog2(VALUE_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              state, state_nxt;
    logic [ITER_W-1:0]   iter;
    logic [VALUE_W-1:0]  bin_sr;
    logic [15:0]         bcd_acc;
    logic                err_pending;
    logic [15:0]         digits;
    logic                err_latched;
    logic                load_go;
    logic                last_iter;

    logic [PRE_W-1:0]    presc;
    logic                wrap;
    logic [1:0]          idx, idx_nxt;
    logic [3:0]          nib;
    logic [7:0]          seg_nxt, an_nxt;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
    function automatic logic [15:0] dabble(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'h03;
            4'd1:    seg_code = 8'h9F;
            4'd2:    seg_code = 8'h25;
            4'd3:    seg_code = 8'h0D;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h49;
            4'd6:    seg_code = 8'h41;
            4'd7:    seg_code = 8'h1F;
            4'd8:    seg_code = 8'h01;
            4'd9:    seg_code = 8'h09;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    assign load_go   = (state == IDLE) && LOAD;
    assign last_iter = (iter == ITER_W'(VALUE_W - 1));
    assign BUSY      = (state != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            iter        <= '0;
            digits      <= '0;
            err_latched <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_go)
                iter <= '0;
            else if (state == SHIFT)
                iter <= iter + 1'b1;
            if (state == COMMIT) begin
                digits      <= bcd_acc;
                err_latched <= err_pending;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (LOAD) state_nxt = SHIFT;
            SHIFT:   if (last_iter) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath carries no reset; it is always reloaded before use.
    always_ff @(posedge CLK) begin
        if (load_go) begin
            bin_sr      <= VALUE;
            bcd_acc     <= '0;
            err_pending <= ERR;
        end else if (state == SHIFT) begin
            {bcd_acc, bin_sr} <= {dabble(bcd_acc), bin_sr} << 1;
        end
    end

    assign wrap    = (presc == PRE_W'(SCAN_DIV - 1));
    assign idx_nxt = idx + 2'd1;
    assign an_nxt  = ~(8'h80 >> idx_nxt);

    always_comb begin
        case (idx_nxt)
            2'd0:    nib = digits[15:12];
            2'd1:    nib = digits[11:8];
            2'd2:    nib = digits[7:4];
            default: nib = digits[3:0];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lead_zero;

    always_comb begin
        case (idx_nxt)
            2'd0:    lead_zero = (digits[15:12] == 4'd0);
            2'd1:    lead_zero = (digits[15:8] == 8'd0);
            2'd2:    lead_zero = (digits[15:4] == 12'd0);
            default: lead_zero = 1'b0;
        endcase
    end
`endif

    always_comb begin
        seg_nxt = seg_code(nib);
`ifdef LEADING_ZERO_BLANK_EN
        if (lead_zero) seg_nxt = 8'hFF;
`endif
        if (err_latched) seg_nxt = 8'hFF;
    end

    // Index advances on the same wrap that registers the bus, so it shows the new slot.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc   <= '0;
            idx     <= 2'd0;
            DISPLAY <= 16'hFFFF;
        end else if (wrap) begin
            presc   <= '0;
            idx     <= idx_nxt;
            DISPLAY <= {seg_nxt, an_nxt};
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule
